// File: rtl/mlp_pkg.sv
// Shared types and width helpers for the MLP inference sequencer.
package mlp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_W,
        ST_LOAD_X,
        ST_MAC,
        ST_STORE,
        ST_WB,
        ST_DONE
    } state_e;

    function automatic int w_depth(input int dim, input int layers);
        return layers * dim * dim;
    endfunction

    function automatic int w_aw(input int dim, input int layers);
        return $clog2(layers * dim * dim);
    endfunction

    function automatic int x_aw(input int dim);
        return $clog2(dim);
    endfunction

    function automatic int l_w(input int layers);
        return $clog2(layers + 1);
    endfunction

endpackage

// File: rtl/mlp_ctrl_if.sv
// Handshake and SRAM-strobe bundle between the MLP sequencer and its host/datapath.
interface mlp_ctrl_if #(
    parameter int DIM    = 16,
    parameter int LAYERS = 4
);
    import mlp_pkg::*;

    localparam int W_AW = w_aw(DIM, LAYERS);
    localparam int X_AW = x_aw(DIM);
    localparam int L_W  = l_w(LAYERS);

    logic            init_valid_i;
    logic            init_ready_o;
    logic            start_valid_i;
    logic            start_ready_o;
    logic [L_W-1:0]  cfg_layers_i;
    logic            result_valid_o;
    logic            result_ready_i;
    logic            result_bank_o;
    logic            w_ren_o;
    logic            w_wen_o;
    logic [W_AW-1:0] w_addr_o;
    logic            x_ren_o;
    logic            x_wen_o;
    logic            x_sel_o;
    logic [X_AW-1:0] x_addr_o;
    logic            partial_sum_store_o;
    logic            x_sram_write_back_o;

    modport master (
        output init_valid_i, start_valid_i, cfg_layers_i, result_ready_i,
        input  init_ready_o, start_ready_o, result_valid_o, result_bank_o,
        input  w_ren_o, w_wen_o, w_addr_o, x_ren_o, x_wen_o, x_sel_o, x_addr_o,
        input  partial_sum_store_o, x_sram_write_back_o
    );

    modport slave (
        input  init_valid_i, start_valid_i, cfg_layers_i, result_ready_i,
        output init_ready_o, start_ready_o, result_valid_o, result_bank_o,
        output w_ren_o, w_wen_o, w_addr_o, x_ren_o, x_wen_o, x_sel_o, x_addr_o,
        output partial_sum_store_o, x_sram_write_back_o
    );

endinterface

// File: rtl/mlp_loop_cnt.sv
// Wrap counter: counts 0..max_i while enabled, pulses wrap_o on the terminal count.
module mlp_loop_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == max_i);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mlp_ctrl.sv
// MLP inference sequencer: loads weights, stages inputs, then walks layer/neuron/input loops.
//   state   | meaning
//   IDLE    | waiting for init or start handshake
//   INIT_W  | streaming W_DEPTH weight writes
//   LOAD_X  | writing DIM inputs into X bank 0
//   MAC     | reading DIM weight/activation pairs for one neuron
//   STORE   | accumulator captures the sum (covers SRAM read latency)
//   WB      | activation written to the opposite X bank
//   DONE    | result valid until the consumer accepts it
module mlp_ctrl
    import mlp_pkg::*;
#(
    parameter int DIM    = 16,
    parameter int LAYERS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mlp_ctrl_if.slave  bus
);

    localparam int W_DEPTH = w_depth(DIM, LAYERS);
    localparam int W_AW    = w_aw(DIM, LAYERS);
    localparam int X_AW    = x_aw(DIM);
    localparam int L_W     = l_w(LAYERS);

    state_e          state_q, state_d;
    logic            wl_q, wl_d;
    logic            src_q, src_d;
    logic [L_W-1:0]  nl_q, nl_d;

    logic [W_AW-1:0] a_cnt, a_max;
    logic [X_AW-1:0] i_cnt, j_cnt;
    logic [L_W-1:0]  l_cnt;
    logic            a_wrap, i_wrap, j_wrap, l_wrap;
    logic            a_en, i_en, j_en;

    assign a_en  = (state_q == ST_INIT_W) || (state_q == ST_LOAD_X);
    assign a_max = (state_q == ST_INIT_W) ? W_AW'(W_DEPTH - 1) : W_AW'(DIM - 1);
    assign i_en  = (state_q == ST_MAC);
    assign j_en  = (state_q == ST_WB);

    mlp_loop_cnt #(.WIDTH(W_AW)) u_a_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(a_en), .max_i(a_max),
        .cnt_o(a_cnt), .wrap_o(a_wrap)
    );

    mlp_loop_cnt #(.WIDTH(X_AW)) u_i_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(i_en), .max_i(X_AW'(DIM - 1)),
        .cnt_o(i_cnt), .wrap_o(i_wrap)
    );

    mlp_loop_cnt #(.WIDTH(X_AW)) u_j_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(j_en), .max_i(X_AW'(DIM - 1)),
        .cnt_o(j_cnt), .wrap_o(j_wrap)
    );

    mlp_loop_cnt #(.WIDTH(L_W)) u_l_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(j_wrap), .max_i(nl_q - 1'b1),
        .cnt_o(l_cnt), .wrap_o(l_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wl_q    <= 1'b0;
            src_q   <= 1'b0;
            nl_q    <= '0;
        end else begin
            state_q <= state_d;
            wl_q    <= wl_d;
            src_q   <= src_d;
            nl_q    <= nl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wl_d    = wl_q;
        src_d   = src_q;
        nl_d    = nl_q;
        unique case (state_q)
            ST_IDLE: begin
                // init has priority over a simultaneous start
                if (bus.init_valid_i) begin
                    state_d = ST_INIT_W;
                end else if (bus.start_valid_i && wl_q) begin
                    state_d = ST_LOAD_X;
                    if (bus.cfg_layers_i == '0)                  nl_d = L_W'(1);
                    else if (bus.cfg_layers_i > L_W'(LAYERS))    nl_d = L_W'(LAYERS);
                    else                                         nl_d = bus.cfg_layers_i;
                end
            end
            ST_INIT_W: if (a_wrap) begin
                wl_d    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_LOAD_X: if (a_wrap) begin
                src_d   = 1'b0;
                state_d = ST_MAC;
            end
            ST_MAC:   if (i_wrap) state_d = ST_STORE;
            ST_STORE: state_d = ST_WB;
            ST_WB: begin
                if (!j_wrap) begin
                    state_d = ST_MAC;
                end else begin
                    src_d   = ~src_q;
                    state_d = l_wrap ? ST_DONE : ST_MAC;
                end
            end
            ST_DONE:  if (bus.result_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.init_ready_o        = 1'b0;
        bus.start_ready_o       = 1'b0;
        bus.result_valid_o      = 1'b0;
        bus.result_bank_o       = 1'b0;
        bus.w_ren_o             = 1'b0;
        bus.w_wen_o             = 1'b0;
        bus.w_addr_o            = '0;
        bus.x_ren_o             = 1'b0;
        bus.x_wen_o             = 1'b0;
        bus.x_sel_o             = 1'b0;
        bus.x_addr_o            = '0;
        bus.partial_sum_store_o = 1'b0;
        bus.x_sram_write_back_o = 1'b0;
        // outputs are silenced for the whole reset cycle, not just after it
        if (!rst_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    bus.init_ready_o  = 1'b1;
                    bus.start_ready_o = wl_q;
                end
                ST_INIT_W: begin
                    bus.w_wen_o  = 1'b1;
                    bus.w_addr_o = a_cnt;
                end
                ST_LOAD_X: begin
                    bus.x_wen_o  = 1'b1;
                    bus.x_addr_o = a_cnt[X_AW-1:0];
                end
                ST_MAC: begin
                    bus.w_ren_o  = 1'b1;
                    bus.x_ren_o  = 1'b1;
                    bus.w_addr_o = W_AW'(l_cnt) * W_AW'(DIM * DIM)
                                 + W_AW'(j_cnt) * W_AW'(DIM) + W_AW'(i_cnt);
                    bus.x_addr_o = i_cnt;
                    bus.x_sel_o  = src_q;
                end
                ST_STORE: bus.partial_sum_store_o = 1'b1;
                ST_WB: begin
                    bus.x_sram_write_back_o = 1'b1;
                    bus.x_wen_o             = 1'b1;
                    bus.x_sel_o             = ~src_q;
                    bus.x_addr_o            = j_cnt;
                end
                ST_DONE: begin
                    bus.result_valid_o = 1'b1;
                    bus.result_bank_o  = src_q;
                end
                default: ;
            endcase
        end
    end

endmodule
